// File: rtl/proc_cu_pkg.sv
// Shared types and encodings for the 16-bit processor control unit.
package proc_cu_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] rf_w_addr;
        logic       rf_w_en;
        logic [3:0] rf_ra_addr;
        logic [3:0] rf_rb_addr;
        logic [2:0] alu_s0;
        logic       halted;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_HALT);
    endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Control bus between the control unit (master) and the IR/datapath side (slave).
interface proc_control_unit_if;
    logic [15:0] IR;
    logic        PC_clr;
    logic        PC_up;
    logic        IR_ld;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic        Halted;
    logic [3:0]  State;

    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted, State
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted, State
    );
endinterface

// File: rtl/proc_cu_outdec.sv
// Moore output decoder: control word as a pure function of state and IR fields.
module proc_cu_outdec
    import proc_cu_pkg::*;
(
    input  state_t      state_i,
    input  logic [15:0] ir_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_INIT: ctrl_o.pc_clr = 1'b1;
            S_FETCH: begin
                ctrl_o.ir_ld = 1'b1;
                ctrl_o.pc_up = 1'b1;
            end
            // LOAD_A holds the read address through the RAM latency; LOAD_B commits.
            S_LOAD_A, S_LOAD_B: begin
                ctrl_o.d_addr    = ir_i[11:4];
                ctrl_o.rf_s      = 1'b1;
                ctrl_o.rf_w_addr = ir_i[3:0];
                ctrl_o.rf_w_en   = (state_i == S_LOAD_B);
            end
            S_STORE: begin
                ctrl_o.d_addr     = ir_i[11:4];
                ctrl_o.rf_ra_addr = ir_i[3:0];
                ctrl_o.alu_s0     = ALU_PASS_A;
                ctrl_o.d_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                ctrl_o.rf_ra_addr = ir_i[11:8];
                ctrl_o.rf_rb_addr = ir_i[7:4];
                ctrl_o.rf_w_addr  = ir_i[3:0];
                ctrl_o.rf_w_en    = 1'b1;
                ctrl_o.alu_s0     = (state_i == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT: ctrl_o.halted = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/proc_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit datapath.
// Define CU_ILLEGAL_OP_HALT_EN to halt on illegal opcodes; otherwise they run as NOOP.
//
// state    | meaning
// ---------+------------------------------------------------
// INIT     | PC cleared; held here during Reset
// FETCH    | IR loads, PC increments
// DECODE   | new IR visible, dispatch on opcode
// NOOP     | no operation (also illegal ops when not halting)
// LOAD_A   | RAM read address presented, waiting on read latency
// LOAD_B   | RAM read data written to register file
// STORE    | register written to RAM
// ADD/SUB  | ALU result written to register file
// HALT     | stopped until Reset
module proc_control_unit
    import proc_cu_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset,
    proc_control_unit_if.master    bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (bus.IR[15:12])
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
`ifdef CU_ILLEGAL_OP_HALT_EN
                    default:  state_d = S_HALT;
`else
                    default:  state_d = S_NOOP;
`endif
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP, S_STORE, S_ADD, S_SUB, S_LOAD_B: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    proc_cu_outdec u_outdec (
        .state_i (state_q),
        .ir_i    (bus.IR),
        .ctrl_o  (ctrl)
    );

    assign bus.PC_clr     = ctrl.pc_clr;
    assign bus.PC_up      = ctrl.pc_up;
    assign bus.IR_ld      = ctrl.ir_ld;
    assign bus.D_addr     = ctrl.d_addr;
    assign bus.D_wr       = ctrl.d_wr;
    assign bus.RF_s       = ctrl.rf_s;
    assign bus.RF_W_addr  = ctrl.rf_w_addr;
    assign bus.RF_W_en    = ctrl.rf_w_en;
    assign bus.RF_Ra_addr = ctrl.rf_ra_addr;
    assign bus.RF_Rb_addr = ctrl.rf_rb_addr;
    assign bus.ALU_s0     = ctrl.alu_s0;
    assign bus.Halted     = ctrl.halted;
    assign bus.State      = state_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed scoreboard bench for proc_control_unit.
module tb_proc_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       halted;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    proc_control_unit_if bus();

    proc_control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    function automatic exp_t mk(input logic [3:0] st, input logic pc_clr, input logic pc_up,
                                input logic ir_ld, input logic [7:0] d_addr, input logic d_wr,
                                input logic rf_s, input logic [3:0] w_addr, input logic w_en,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu,
                                input logic halted);
        exp_t e;
        e = '{st, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu, halted};
        return e;
    endfunction

    function automatic exp_t z(input logic [3:0] st);
        return mk(st, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
    endfunction

    function automatic exp_t observe();
        return mk(bus.State, bus.PC_clr, bus.PC_up, bus.IR_ld, bus.D_addr, bus.D_wr, bus.RF_s,
                  bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0,
                  bus.Halted);
    endfunction

    task automatic check(input string tag);
        exp_t o;
        exp_t e;
        o = observe();
        total++;
        assert (q.size() != 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, o);
            return;
        end
        e = q.pop_front();
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (state %0d vs %0d)", tag, o, e, o.st, e.st);
        end
    endtask

    task automatic step(input string tag, input exp_t e);
        q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        check(tag);
    endtask

    // Caller sits at a negedge; reset is asserted mid-cycle, away from any edge.
    task automatic do_reset();
        exp_t ei;
        ei = mk(4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
        #2 Reset = 1'b1;
        #1;
        q.push_back(ei);
        check("rst_async");
        @(posedge Clk);
        @(negedge Clk);
        q.push_back(ei);
        check("rst_hold");
        Reset = 1'b0;
        #1;
        q.push_back(ei);
        check("init_after_release");
    endtask

    exp_t e_fetch;
    exp_t e_lda;
    exp_t e_ldb;

    initial begin
        e_fetch = mk(4'd1, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
        e_lda   = mk(4'd4, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'b000, 0);
        e_ldb   = mk(4'd5, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'b000, 0);
        bus.IR = 16'h0000;
        @(negedge Clk);
        do_reset();

        bus.IR = 16'h2A53;
        step("first_fetch", e_fetch);
        step("ld_decode", z(4'd2));
        step("ld_a", e_lda);
        step("ld_b", e_ldb);
        step("ld_next_fetch", e_fetch);

        bus.IR = 16'h3127;
        step("add_decode", z(4'd2));
        step("add_exec", mk(4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h7, 1, 4'h1, 4'h2, 3'b001, 0));
        step("add_next_fetch", e_fetch);

        bus.IR = 16'h4127;
        step("sub_decode", z(4'd2));
        step("sub_exec", mk(4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h7, 1, 4'h1, 4'h2, 3'b010, 0));
        step("sub_next_fetch", e_fetch);

        bus.IR = 16'h1FF4;
        step("st_decode", z(4'd2));
        step("st_exec", mk(4'd6, 0, 0, 0, 8'hFF, 1, 0, 4'h0, 0, 4'h4, 4'h0, 3'b000, 0));
        step("st_len3_fetch", e_fetch);

        bus.IR = 16'hF000;
        step("ill_decode", z(4'd2));
`ifdef CU_ILLEGAL_OP_HALT_EN
        step("ill_halt", mk(4'd9, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 1));
        step("ill_halt_stay", mk(4'd9, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 1));
        do_reset();
        step("ill_refetch", e_fetch);
`else
        step("ill_noop", z(4'd3));
        step("ill_next_fetch", e_fetch);
`endif

        bus.IR = 16'h0000;
        step("noop_decode", z(4'd2));
        step("noop_exec", z(4'd3));
        step("noop_next_fetch", e_fetch);

        bus.IR = 16'h2A53;
        step("ldr_decode", z(4'd2));
        step("ldr_a", e_lda);
        do_reset();
        step("ldr_refetch", e_fetch);

        bus.IR = 16'h5000;
        step("halt_decode", z(4'd2));
        for (int i = 0; i < 20; i++)
            step($sformatf("halt_%0d", i),
                 mk(4'd9, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 1));
        do_reset();
        step("post_halt_fetch", e_fetch);

        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain leftover=%0d expected=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
